// File: rtl/dec_hit_pkg.sv
// Shared definitions for dec_hit_counter.
// Contents: channel count, index width, FSM state type and fault-cause codes.
package dec_hit_pkg;

    localparam int unsigned NCH   = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        RUN,
        FAULT
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_MULTI    = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q
//   clr  - synchronous clear, takes priority over inc
//   inc  - count enable
//   q    - current count
module sat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/dec_hit_counter.sv
// Per-channel hit statistics for a 3-to-8 decoder output.
// Registers the one-hot word and its complement, checks consistency one cycle later, counts
// valid one-hot samples per channel with saturation and latches the first fault cause.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   dec_in, ndec_in  - decoder output and its complement
//   clr              - synchronous clear of counters, fault state and outputs
//   rd_sel, rd_cnt   - registered counter read port
//   hit, last_ch     - count pulse and most recently counted channel
//   err, err_code    - sticky fault flag and first cause
module dec_hit_counter
    import dec_hit_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       dec_in,
    input  logic [7:0]       ndec_in,
    input  logic             clr,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             hit,
    output logic [2:0]       last_ch,
    output logic             err,
    output logic [1:0]       err_code
);

    logic [7:0]       dec_q;
    logic [7:0]       ndec_q;
    state_e           state;
    logic [3:0]       pop;
    logic [2:0]       idx;
    logic             mismatch;
    logic             multi;
    logic             one_hot;
    logic             count_en;
    logic [NCH-1:0]   inc;
    logic [CNT_W-1:0] cnt [NCH];

    // Stage 1 samples every cycle; clr deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q  <= 8'h00;
            ndec_q <= 8'hFF;
        end else begin
            dec_q  <= dec_in;
            ndec_q <= ndec_in;
        end
    end

    always_comb begin
        pop = 4'd0;
        idx = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + {3'b000, dec_q[i]};
            if (dec_q[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign mismatch = (ndec_q != ~dec_q);
    assign multi    = !mismatch && (pop >= 4'd2);
    assign one_hot  = !mismatch && (pop == 4'd1);
    assign count_en = (state == RUN) && !clr && one_hot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            hit      <= 1'b0;
            last_ch  <= 3'd0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (clr) begin
            state    <= RUN;
            hit      <= 1'b0;
            last_ch  <= 3'd0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            hit <= 1'b0;
            case (state)
                RUN: begin
                    if (mismatch) begin
                        state    <= FAULT;
                        err      <= 1'b1;
                        err_code <= ERR_MISMATCH;
                    end else if (multi) begin
                        state    <= FAULT;
                        err      <= 1'b1;
                        err_code <= ERR_MULTI;
                    end else if (one_hot) begin
                        hit     <= 1'b1;
                        last_ch <= idx;
                    end
                end
                FAULT: begin
                    // Hold first cause; only clr/rst leave this state.
                end
                default: state <= RUN;
            endcase
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign inc[g] = count_en && dec_q[g];

        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[g]),
            .q   (cnt[g])
        );
    end

    // Reads the pre-update value: a count landing at this edge shows up one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= cnt[rd_sel];
        end
    end

endmodule

// File: doc/dec_hit_counter.md
# dec_hit_counter

Registered consumer of the 3-to-8 decoder outputs: samples the active-high one-hot word and its complement every clock, checks that they are consistent, and keeps a saturating hit count per channel. It sits directly downstream of the decoder and turns its combinational select lines into clocked per-channel statistics, with a sticky fault flag. Counters are read back through a registered read port.

## Interface
- CNT_W, 4, width of each per-channel saturating counter (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- dec_in  in  8  active-high decoder output, expected one-hot or all-zero
- ndec_in  in  8  complemented decoder output, expected == ~dec_in
- clr  in  1  synchronous clear of counters, fault state and error outputs
- rd_sel  in  3  channel index to read
- rd_cnt  out  CNT_W  registered count of channel rd_sel
- hit  out  1  one-cycle pulse: a valid one-hot sample was counted
- last_ch  out  3  index of the most recently counted channel
- err  out  1  sticky fault flag
- err_code  out  2  first fault cause: 00 none, 01 complement mismatch, 10 multi-hot

## Operation
- Stage 1: dec_in/ndec_in registered into dec_q/ndec_q every cycle, unconditionally (including during FAULT and clr).
- Stage 2 classifies dec_q/ndec_q, priority order:
  - ndec_q != ~dec_q -> mismatch fault (code 01).
  - popcount(dec_q) ≥ 2 -> multi-hot fault (code 10).
  - dec_q == 0 -> idle (decoder disabled); no count, no hit.
  - exactly one bit i set -> hit on channel i.
- FSM, two states:
  - RUN: hit on i -> cnt[i] += 1, saturating at 2^CNT_W-1 (holds, no wrap); last_ch <= i; hit <= 1. Fault -> go FAULT, err <= 1, err_code <= cause; no count that cycle.
  - FAULT: no counting, hit stays 0, last_ch and err_code hold (first cause only); further faults ignored. Leave only via clr or rst.
- clr (either state): all cnt <= 0, err <= 0, err_code <= 00, hit <= 0, last_ch <= 0, state <= RUN. clr has priority over any stage-2 event in the same cycle (that event is discarded). Stage-1 contents are kept, so the sample registered at the clr edge is evaluated normally in the next cycle.
- Saturated channel still produces hit and updates last_ch.
- Read port: rd_cnt <= cnt[rd_sel] every cycle; reflects counter value before that edge's update.

## Timing
- Reset values: dec_q 8'h00, ndec_q 8'hFF, all cnt 0, rd_cnt 0, hit 0, last_ch 0, err 0, err_code 00, state RUN.
- Reset mid-operation clears everything immediately (asynchronous), regardless of clock.
- dec_in applied before edge k -> counter/hit/last_ch/err updated at edge k+1 (2-cycle input-to-output latency).
- rd_sel change before edge k -> rd_cnt valid after edge k; a count landing at edge k is visible on rd_cnt after edge k+1.
- hit is high for exactly one cycle per counted sample; back-to-back valid samples give continuous hit.
- No handshake on input; every cycle is a sample.

## Structure
- Package dec_hit_pkg: NCH = 8, state enum {RUN, FAULT}, err_code constants ERR_NONE/ERR_MISMATCH/ERR_MULTI.
- One sub-module: sat_counter (CNT_W parameter, inc, clr, async rst, q), instantiated 8 times.
- One-hot-to-index encode and popcount stay inline in the top.

## Test plan
- Reset, then dec_in=8'h04, ndec_in=8'hFB for 3 cycles -> hit high 3 cycles starting 2 cycles after first sample, last_ch=2, cnt[2]=3 via rd_sel=2.
- dec_in=8'h80/ndec_in=8'h7F for 20 cycles, CNT_W=4 -> cnt[7] saturates at 15, hit stays 1 throughout, no error.
- dec_in=8'h00/ndec_in=8'hFF (decoder disabled) 5 cycles -> no hit, counters unchanged, err=0.
- dec_in=8'h01, ndec_in=8'hFF -> err=1, err_code=01 at edge k+1; subsequent valid one-hot samples not counted; then dec_in=8'h03/ndec_in=8'hFC -> err_code stays 01.
- From FAULT, pulse clr in the same cycle a valid hit reaches stage 2 -> counters 0, err 0, that hit discarded; next valid sample counted normally.
- Assert rst mid-run between clock edges with nonzero counts -> all outputs reset immediately, before the next edge.
